// File: rtl/raman_pkg.sv
// Shared types and width constants for the Raman acquisition timing chain.
package raman_pkg;

  localparam int W_POINT   = 11;
  localparam int W_MEASURE = 17;
  localparam int W_SAVE    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    SAVE = 2'd3
  } seq_state_t;

  // Modulo increment used for the save counter (last value wraps to zero).
  function automatic logic [W_SAVE-1:0] wrap_inc_save(input logic [W_SAVE-1:0] v,
                                                      input logic [W_SAVE-1:0] last);
    return (v == last) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/meas_sequencer_trig_sync.sv
// External laser-sync synchroniser: two-flop metastability guard plus a
// registered rising-edge pulse (one clock wide, three clocks after the raw edge).
module trig_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic trig_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= trig_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/meas_sequencer.sv
// Master timing sequencer: point / measure / save counters, laser and ADC strobes,
// save handshake. Define SEQ_TRIG_EXT_EN to gate every shot on an external trigger.
module meas_sequencer
  import raman_pkg::*;
#(
  parameter int POINTS    = 10,
  parameter int GUARD     = 64,
  parameter int MEASURES  = 100,
  parameter int SAVES     = 16,
  parameter int PULSE_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 save_ack,
`ifdef SEQ_TRIG_EXT_EN
  input  logic                 ext_trig,
`endif
  output logic [W_POINT-1:0]   cnt_point,
  output logic [W_MEASURE-1:0] cnt_measure,
  output logic [W_SAVE-1:0]    cnt_save,
  output logic                 laser_pulse,
  output logic                 adc_valid,
  output logic                 save_req,
  output logic                 busy,
  output logic                 done
);

  localparam logic [W_POINT-1:0]   PT_LAST  = W_POINT'(POINTS + GUARD - 1);
  localparam logic [W_POINT-1:0]   PT_PULSE = W_POINT'(PULSE_LEN);
  localparam logic [W_POINT-1:0]   PT_WIN   = W_POINT'(POINTS);
  localparam logic [W_MEASURE-1:0] MS_LAST  = W_MEASURE'(MEASURES - 1);
  localparam logic [W_SAVE-1:0]    SV_LAST  = W_SAVE'(SAVES - 1);

  logic trig_rise;

`ifdef SEQ_TRIG_EXT_EN
  localparam seq_state_t SHOT_STATE = ARM;

  trig_sync u_trig_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .trig_i (ext_trig),
    .rise_o (trig_rise)
  );
`else
  localparam seq_state_t SHOT_STATE = RUN;

  // ARM is unreachable here; a constant trigger makes it fall straight into RUN.
  assign trig_rise = 1'b1;
`endif

  seq_state_t             state_q;
  logic [W_POINT-1:0]     cnt_point_q;
  logic [W_MEASURE-1:0]   cnt_measure_q;
  logic [W_SAVE-1:0]      cnt_save_q;
  logic [W_SAVE-1:0]      cnt_save_d;
  logic                   save_req_q;
  logic                   done_q;
  logic                   stop_pending_q;

  assign cnt_save_d = wrap_inc_save(cnt_save_q, SV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_point_q    <= '0;
      cnt_measure_q  <= '0;
      cnt_save_q     <= '0;
      save_req_q     <= 1'b0;
      done_q         <= 1'b0;
      stop_pending_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_point_q   <= '0;
          cnt_measure_q <= '0;
          if (start) begin
            state_q <= SHOT_STATE;
          end
        end

        ARM: begin
          if (stop) begin
            stop_pending_q <= 1'b1;
          end
          if (trig_rise) begin
            state_q <= RUN;
          end
        end

        RUN: begin
          if (stop) begin
            stop_pending_q <= 1'b1;
          end
          if (cnt_point_q == PT_LAST) begin
            cnt_point_q <= '0;
            if (cnt_measure_q == MS_LAST) begin
              cnt_measure_q <= '0;
              save_req_q    <= 1'b1;
              state_q       <= SAVE;
            end else begin
              cnt_measure_q <= cnt_measure_q + 1'b1;
              state_q       <= SHOT_STATE;
            end
          end else begin
            cnt_point_q <= cnt_point_q + 1'b1;
          end
        end

        SAVE: begin
          if (save_ack && save_req_q) begin
            cnt_save_q <= cnt_save_d;
            save_req_q <= 1'b0;
            // A stop arriving together with the ack still ends the acquisition.
            if (stop_pending_q || stop) begin
              state_q        <= IDLE;
              done_q         <= 1'b1;
              stop_pending_q <= 1'b0;
            end else begin
              state_q <= SHOT_STATE;
            end
          end else if (stop) begin
            stop_pending_q <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cnt_point   = cnt_point_q;
  assign cnt_measure = cnt_measure_q;
  assign cnt_save    = cnt_save_q;
  assign save_req    = save_req_q;
  assign done        = done_q;
  assign busy        = (state_q != IDLE);
  assign laser_pulse = (state_q == RUN) && (cnt_point_q < PT_PULSE);
  assign adc_valid   = (state_q == RUN) && (cnt_point_q < PT_WIN);

endmodule
